// File: rtl/multi_clock_divider.sv
// N_CH independent square-wave dividers with glitch-free divisor reload, one-cycle tick per toggle.
// Latency: all outputs registered, 1 cycle from inputs; no backpressure (free-running).
module multi_clock_divider #(
  parameter int                      N_CH     = 2,
  parameter int                      CNT_W    = 26,
  parameter logic [N_CH*CNT_W-1:0]   DIV_INIT = {26'd100_000, 26'd1_000_000}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     en,
  input  logic                sync_clr,
  input  logic                wr_en,
  input  logic [3:0]          wr_ch,
  input  logic [CNT_W-1:0]    wr_div,
  output logic [N_CH-1:0]     div_clk,
  output logic [N_CH-1:0]     tick
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] shd;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] cnt;
    logic             dclk;
    logic             tck;
    logic             wr_hit;
    logic [CNT_W-1:0] shd_nxt;

    // Channel indices >= N_CH never match, so out-of-range writes drop out here.
    assign wr_hit  = wr_en && (wr_ch == 4'(i));
    // A write landing on a reload edge is forwarded straight into act.
    assign shd_nxt = wr_hit ? wr_div : shd;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shd  <= DIV_INIT[i*CNT_W +: CNT_W];
        act  <= DIV_INIT[i*CNT_W +: CNT_W];
        cnt  <= '0;
        dclk <= 1'b0;
        tck  <= 1'b0;
      end else begin
        shd <= shd_nxt;
        if (sync_clr || !en[i]) begin
          cnt  <= '0;
          dclk <= 1'b0;
          tck  <= 1'b0;
          act  <= shd_nxt;
        end else if (cnt == act) begin
          cnt  <= '0;
          dclk <= ~dclk;
          tck  <= 1'b1;
          act  <= shd_nxt;
        end else begin
          cnt  <= cnt + CNT_W'(1);
          tck  <= 1'b0;
        end
      end
    end

    assign div_clk[i] = dclk;
    assign tick[i]    = tck;
  end

endmodule
